// File: rtl/dht11_pkg.sv
// +----------------------------------------------------------------------+
// | dht11_pkg                                                            |
// | Shared states, timing defaults and frame helpers for the DHT11 host. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dht11_pkg;

  localparam int c_start_low_us    = 18000;
  localparam int c_release_us      = 30;
  localparam int c_resp_timeout_us = 100;
  localparam int c_bit_thresh_us   = 50;
  localparam int c_holdoff_us      = 1000000;
  localparam int c_frame_bits      = 40;
  localparam int c_us_w            = 20;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_RESP_LOW  = 4'd3,
    ST_RESP_HIGH = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_CHECK     = 4'd7,
    ST_HOLDOFF   = 4'd8
  } state_t;

  // Byte 0 of the frame is the modulo-256 sum of the four data bytes.
  function automatic logic [7:0] frame_sum(input logic [c_frame_bits-1:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dht11_controller_us_timer.sv
// +----------------------------------------------------------------------+
// | us_timer                                                             |
// | Free-running microsecond prescaler plus clearable microsecond count. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module us_timer #(
  parameter int CLKS_PER_US = 50,
  parameter int US_W        = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic            us_tick,
  output logic [US_W-1:0] us_count
);

  localparam int              c_pw      = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [c_pw-1:0] c_pre_max = c_pw'(CLKS_PER_US - 1);

  logic [c_pw-1:0] r_pre;
  logic [US_W-1:0] r_cnt;

  assign us_tick = (r_pre == c_pre_max);

  // The clear cycle already reads as zero so the new state never sees a stale count.
  assign us_count = clr ? '0 : r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= us_tick ? '0 : r_pre + 1'b1;
      if (clr)
        r_cnt <= us_tick ? US_W'(1) : '0;
      else if (us_tick)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dht11_controller.sv
// +----------------------------------------------------------------------+
// | dht11_controller                                                     |
// | Single-wire DHT11 host: start pulse, handshake, 40-bit capture, sum. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dht11_controller
  import dht11_pkg::*;
#(
  parameter int CLKS_PER_US     = 50,
  parameter int START_LOW_US    = c_start_low_us,
  parameter int RELEASE_US      = c_release_us,
  parameter int RESP_TIMEOUT_US = c_resp_timeout_us,
  parameter int BIT_THRESH_US   = c_bit_thresh_us,
  parameter int HOLDOFF_US      = c_holdoff_us
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       auto_en,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       chk_err,
  output logic       tmo_err
);

  localparam logic [c_us_w-1:0] c_start_last   = c_us_w'(START_LOW_US - 1);
  localparam logic [c_us_w-1:0] c_release      = c_us_w'(RELEASE_US);
  localparam logic [c_us_w-1:0] c_tmo_last     = c_us_w'(RESP_TIMEOUT_US - 1);
  localparam logic [c_us_w-1:0] c_thresh       = c_us_w'(BIT_THRESH_US);
  localparam logic [c_us_w-1:0] c_holdoff_last = c_us_w'(HOLDOFF_US - 1);
  localparam logic [5:0]        c_last_bit     = 6'(c_frame_bits - 1);

  state_t                  r_state;
  logic                    r_sync1, r_sync2, r_sync3;
  logic                    r_clr, r_oe, r_busy, r_valid, r_chk_err, r_tmo_err;
  logic [5:0]              r_bit_cnt;
  logic [c_frame_bits-1:0] r_shift;
  logic [7:0]              r_hum_int, r_hum_dec, r_temp_int, r_temp_dec;
  logic                    w_tick, w_rise, w_fall, w_tmo;
  logic [c_us_w-1:0]       w_us;

  us_timer #(
    .CLKS_PER_US (CLKS_PER_US),
    .US_W        (c_us_w)
  ) u_us_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (r_clr),
    .us_tick  (w_tick),
    .us_count (w_us)
  );

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;
  assign w_tmo  = w_tick && (w_us == c_tmo_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= dht_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_clr      <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_chk_err  <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_hum_int  <= '0;
      r_hum_dec  <= '0;
      r_temp_int <= '0;
      r_temp_dec <= '0;
    end else begin
      r_clr   <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (start || auto_en) begin
          r_state   <= ST_START_LOW;
          r_clr     <= 1'b1;
          r_oe      <= 1'b1;
          r_busy    <= 1'b1;
          r_chk_err <= 1'b0;
          r_tmo_err <= 1'b0;
        end
        ST_START_LOW: if (w_tick && (w_us == c_start_last)) begin
          r_state <= ST_RELEASE;
          r_clr   <= 1'b1;
          r_oe    <= 1'b0;
        end
        ST_RELEASE: begin
          if ((w_us >= c_release) && !r_sync2) begin
            r_state <= ST_RESP_LOW;
            r_clr   <= 1'b1;
          end else if (w_tmo) begin
            r_state   <= ST_HOLDOFF;
            r_clr     <= 1'b1;
            r_tmo_err <= 1'b1;
          end
        end
        ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH: begin
          if ((r_state == ST_RESP_LOW) && w_rise) begin
            r_state <= ST_RESP_HIGH;
            r_clr   <= 1'b1;
          end else if ((r_state == ST_RESP_HIGH) && w_fall) begin
            r_state   <= ST_BIT_LOW;
            r_clr     <= 1'b1;
            r_bit_cnt <= '0;
          end else if ((r_state == ST_BIT_LOW) && w_rise) begin
            r_state <= ST_BIT_HIGH;
            r_clr   <= 1'b1;
          end else if ((r_state == ST_BIT_HIGH) && w_fall) begin
            // High-phase length decides the bit; the final fall ends the frame.
            r_shift <= {r_shift[c_frame_bits-2:0], (w_us > c_thresh)};
            r_clr   <= 1'b1;
            if (r_bit_cnt == c_last_bit) begin
              r_state <= ST_CHECK;
            end else begin
              r_state   <= ST_BIT_LOW;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_tmo) begin
            r_state   <= ST_HOLDOFF;
            r_clr     <= 1'b1;
            r_tmo_err <= 1'b1;
          end
        end
        ST_CHECK: begin
          r_state <= ST_HOLDOFF;
          r_clr   <= 1'b1;
          if (frame_sum(r_shift) == r_shift[7:0]) begin
            r_hum_int  <= r_shift[39:32];
            r_hum_dec  <= r_shift[31:24];
            r_temp_int <= r_shift[23:16];
            r_temp_dec <= r_shift[15:8];
            r_valid    <= 1'b1;
          end else begin
            r_chk_err <= 1'b1;
          end
        end
        ST_HOLDOFF: if (w_tick && (w_us == c_holdoff_last)) begin
          r_state <= ST_IDLE;
          r_clr   <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dht_oe   = r_oe;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign hum_int  = r_hum_int;
  assign hum_dec  = r_hum_dec;
  assign temp_int = r_temp_int;
  assign temp_dec = r_temp_dec;
  assign chk_err  = r_chk_err;
  assign tmo_err  = r_tmo_err;

endmodule

`default_nettype wire

// File: doc/dht11_controller.md
Name: dht11_controller

Overview:
- Sequences one DHT11 single-wire transaction:
  - 18 ms start pulse and release;
  - sensor response handshake;
  - capture of 40 data bits;
  - checksum check.
- Publishes humidity/temperature registers and enforces the sensor's minimum re-trigger interval.
- Sits between the pin-level open-drain pad and the display/UART logic.
- Transactions are triggered by a software start pulse or a free-running auto mode.

Parameters:
- CLKS_PER_US, 50, clk cycles per 1 us tick (50 MHz clk).
- START_LOW_US, 18000, host low-pulse length.
- RELEASE_US, 30, host release time before sampling the response.
- RESP_TIMEOUT_US, 100, max duration of any sensor low/high phase.
- BIT_THRESH_US, 50, bit-high longer than this = 1, otherwise 0.
- HOLDOFF_US, 1000000, min gap from end of a transaction to the next start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored unless state is IDLE
- auto_en  in  1  1 = re-trigger automatically after each HOLDOFF
- dht_in  in  1  pad input (asynchronous)
- dht_oe  out  1  1 = drive pad low; 0 = release (pull-up)
- busy  out  1  high in every state except IDLE
- valid  out  1  one-cycle pulse: new good frame latched
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  last good frame bytes
- chk_err  out  1  sticky: last frame had a checksum mismatch
- tmo_err  out  1  sticky: last transaction timed out

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; dht_oe=0, busy=0, valid=0, all data bytes 0x00, chk_err=0, tmo_err=0;
  - prescaler, us counter and bit counter cleared.
- Input sync: dht_in passes through a 2-FF synchronizer (2-cycle latency). Edges are detected on the synced value.
- us_tick: prescaler counts 0..CLKS_PER_US-1 and pulses at wrap. The us counter (20 bits) clears on every state change and increments on us_tick.
- States:
  - IDLE: if start, or auto_en with no holdoff pending → START_LOW. Clear chk_err/tmo_err on entry to START_LOW.
  - START_LOW: dht_oe=1. After START_LOW_US → RELEASE.
  - RELEASE: dht_oe=0. Stay until us count = RELEASE_US, then wait for synced low → RESP_LOW. If RESP_TIMEOUT_US passes first → timeout.
  - RESP_LOW: wait for rising edge → RESP_HIGH.
  - RESP_HIGH: wait for falling edge → BIT_LOW; bit counter = 0.
  - BIT_LOW: wait for rising edge → BIT_HIGH.
  - BIT_HIGH: on falling edge, shift in bit (us count > BIT_THRESH_US) MSB-first into a 40-bit shift register. If bit counter = 39 → CHECK, else increment → BIT_LOW.
  - CHECK (1 cycle):
    - sum = (b4+b3+b2+b1) mod 256 versus b0 (b4 is first byte received).
    - Match: latch bytes hum_int=b4, hum_dec=b3, temp_int=b2, temp_dec=b1; valid=1 for this cycle.
    - Mismatch: chk_err=1; data registers keep their old values.
    - → HOLDOFF.
  - HOLDOFF: busy=1. After HOLDOFF_US → IDLE.
- Timeout: in RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, us count reaching RESP_TIMEOUT_US sets tmo_err=1 → HOLDOFF. dht_oe=0 and no data update.
- The last bit's falling edge (sensor end-of-frame low) completes bit 39; no further edge is awaited.
- start while busy is dropped, not queued. Start and auto trigger in the same IDLE cycle count as a single transaction.
- auto_en deasserted mid-transaction: the current transaction completes; IDLE then waits for start.
- Reset mid-operation releases the pad immediately (dht_oe=0 asynchronously).
- Latency: valid asserts exactly 1 cycle after the bit-39 falling edge is seen on the synced input.

Decomposition:
- Shared package dht11_pkg:
  - state encoding localparams;
  - timing defaults (START_LOW_US, RESP_TIMEOUT_US, BIT_THRESH_US, HOLDOFF_US);
  - FRAME_BITS=40.
- One sub-module, us_timer: prescaler plus clearable 20-bit microsecond counter with us_tick output.
- Sync/edge detect and the FSM stay in dht11_controller.

Test Plan:
All scenarios use CLKS_PER_US=1, START_LOW_US=180, HOLDOFF_US=200, and a behavioural sensor model (response 80 us low / 80 us high; bits 50 us low + 27 us (0) or 70 us (1) high).
- Good frame: start pulse; model sends 0x37 00 18 00 4F → dht_oe high for exactly 180 us then released; valid pulses once; hum_int=55, temp_int=24, chk_err=0.
- Bad checksum: model sends 0x37 00 18 00 50 → no valid, chk_err=1, data registers hold their prior values, busy until HOLDOFF ends.
- No sensor (dht_in held 1): start → tmo_err=1 within RELEASE_US+RESP_TIMEOUT_US after release; then IDLE after 200 us.
- Stuck bit: model holds line high 150 us in bit 12 → tmo_err=1, no valid, dht_oe stays 0.
- Auto mode: auto_en=1, two good frames → two valid pulses; start-low edges spaced ≥ transaction time + 200 us. A start pulse during busy causes no extra transaction.
- Reset mid START_LOW: rst=0 at 90 us → dht_oe=0 and busy=0 immediately, outputs at reset values; after release, a fresh start runs a full 180 us low.
